// File: rtl/hs_npu_mem_sequencer_pkg.sv
// Shared NPU memory-path types and constants.
//   seq_state_t     : sequencer FSM states
//   mem_cmd_t       : strided matrix-transfer command
//   NPU_BURST_WORDS : 32-bit words per memory burst (shared with the memory interface)
//   NPU_CNT_W       : width of the burst-count field
package hs_npu_pkg;

  localparam int NPU_BURST_WORDS = 2;
  localparam int NPU_CNT_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DRAIN,
    S_WR_FILL,
    S_WR_REQ,
    S_WR_WAIT,
    S_ABORT
  } seq_state_t;

  typedef struct packed {
    logic                 write;
    logic [31:0]          base;
    logic [31:0]          stride;
    logic [NPU_CNT_W-1:0] count;
  } mem_cmd_t;

endpackage

// File: rtl/hs_npu_mem_sequencer_if.sv
// Sequencer <-> memory-interface bus.
//   master : sequencer side (drives requests, address, write burst)
//   slave  : memory side (drives ready, read burst, completion pulses)
interface hs_npu_mem_sequencer_if
  import hs_npu_pkg::*;
#(
  parameter int BURST_WORDS = NPU_BURST_WORDS
);
  logic                         mem_read_ready_o;
  logic                         mem_write_valid_o;
  logic                         mem_invalidate_o;
  logic                         mem_ready_i;
  logic                         mem_valid_i;
  logic                         mem_write_done_i;
  logic [31:0]                  mem_addr_o;
  logic [BURST_WORDS-1:0][31:0] mem_rdata_i;
  logic [BURST_WORDS-1:0][31:0] mem_wdata_o;

  modport master (
    output mem_read_ready_o, mem_write_valid_o, mem_invalidate_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_valid_i, mem_write_done_i, mem_rdata_i
  );

  modport slave (
    input  mem_read_ready_o, mem_write_valid_o, mem_invalidate_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_valid_i, mem_write_done_i, mem_rdata_i
  );
endinterface

// File: rtl/hs_npu_mem_sequencer_burst_buffer.sv
// One-burst register file shared by the read and write paths.
//   clr       : reset the word index (abort)
//   load      : parallel load of a whole burst, index back to 0
//   push      : serial write of push_data at the index, index advances
//   pop       : index advances (serial read)
//   par_out   : whole burst, word_out : word at the index
//   last      : index points at the final word of the burst
module hs_npu_burst_buffer
  import hs_npu_pkg::*;
#(
  parameter int BURST_WORDS = NPU_BURST_WORDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         load,
  input  logic [BURST_WORDS-1:0][31:0] par_in,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  output logic [BURST_WORDS-1:0][31:0] par_out,
  output logic [31:0]                  word_out,
  output logic                         last
);
  localparam int IDX_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  logic [BURST_WORDS-1:0][31:0] words_q;
  logic [IDX_W-1:0]             idx;
  logic [IDX_W-1:0]             idx_nxt;

  assign last     = (idx == IDX_W'(BURST_WORDS - 1));
  assign idx_nxt  = last ? '0 : idx + 1'b1;
  assign par_out  = words_q;
  assign word_out = words_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      idx     <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load) begin
      words_q <= par_in;
      idx     <= '0;
    end else if (push) begin
      words_q[idx] <= push_data;
      idx          <= idx_nxt;
    end else if (pop) begin
      idx <= idx_nxt;
    end
  end
endmodule

// File: rtl/hs_npu_mem_sequencer.sv
// NPU memory sequencer: splits a strided matrix-transfer command into
// per-burst memory requests. Reads unpack each burst into a word stream,
// writes pack a word stream into bursts.
//   cmd_*   : command handshake (write, base, stride, burst count)
//   abort_i : cancel current command (one ABORT cycle, no done)
//   busy_o / done_o : status and one-cycle completion pulse
//   rd_*    : read word stream out, wr_* : write word stream in
//   mem     : memory-interface bus (master side)
module hs_npu_mem_sequencer
  import hs_npu_pkg::*;
#(
  parameter int BURST_WORDS = NPU_BURST_WORDS,
  parameter int CNT_W       = NPU_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_write_i,
  input  logic [31:0]                   cmd_base_i,
  input  logic [31:0]                   cmd_stride_i,
  input  logic [CNT_W-1:0]              cmd_count_i,
  input  logic                          abort_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [31:0]                   rd_data_o,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  hs_npu_mem_sequencer_if.master        mem
);
  seq_state_t       state;
  mem_cmd_t         cmd;
  logic [31:0]      addr, stride;
  logic [CNT_W-1:0] remaining;
  logic             done_q, rd_vld_q, wr_rdy_q, rreq_q, wreq_q, inval_q;

  logic             abort_hit, buf_load, buf_push, buf_pop, buf_last, last_burst;
  logic [31:0]      next_addr;

  assign cmd = '{write: cmd_write_i, base: cmd_base_i, stride: cmd_stride_i,
                 count: NPU_CNT_W'(cmd_count_i)};

  // Abort wins over every other event; idle and the abort cycle itself ignore it.
  assign abort_hit  = abort_i && (state != S_IDLE) && (state != S_ABORT);
  assign buf_load   = !abort_hit && (state == S_RD_REQ) && mem.mem_valid_i;
  assign buf_pop    = !abort_hit && (state == S_RD_DRAIN) && rd_vld_q && rd_ready_i;
  assign buf_push   = !abort_hit && (state == S_WR_FILL) && wr_rdy_q && wr_valid_i;
  assign next_addr  = addr + stride;
  assign last_burst = (remaining == CNT_W'(1));

  hs_npu_burst_buffer #(.BURST_WORDS(BURST_WORDS)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort_hit),
    .load      (buf_load),
    .par_in    (mem.mem_rdata_i),
    .push      (buf_push),
    .push_data (wr_data_i),
    .pop       (buf_pop),
    .par_out   (mem.mem_wdata_o),
    .word_out  (rd_data_o),
    .last      (buf_last)
  );

  assign busy_o                = (state != S_IDLE);
  assign cmd_ready_o           = (state == S_IDLE);
  assign done_o                = done_q;
  assign rd_valid_o            = rd_vld_q;
  assign wr_ready_o            = wr_rdy_q;
  assign mem.mem_read_ready_o  = rreq_q;
  assign mem.mem_write_valid_o = wreq_q;
  assign mem.mem_invalidate_o  = inval_q;
  assign mem.mem_addr_o        = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      stride    <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_rdy_q  <= 1'b0;
      rreq_q    <= 1'b0;
      wreq_q    <= 1'b0;
      inval_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_hit) begin
        state    <= S_ABORT;
        inval_q  <= 1'b1;
        rreq_q   <= 1'b0;
        wreq_q   <= 1'b0;
        rd_vld_q <= 1'b0;
        wr_rdy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (cmd_valid_i) begin
            addr      <= cmd.base;
            stride    <= cmd.stride;
            remaining <= CNT_W'(cmd.count);
            if (cmd.count == '0) begin
              done_q <= 1'b1;  // empty transfer completes without touching memory
            end else if (cmd.write) begin
              state    <= S_WR_FILL;
              wr_rdy_q <= 1'b1;
            end else begin
              state  <= S_RD_REQ;
              rreq_q <= 1'b1;
            end
          end
          S_RD_REQ: if (mem.mem_valid_i) begin
            state    <= S_RD_DRAIN;
            rreq_q   <= 1'b0;
            rd_vld_q <= 1'b1;
          end
          S_RD_DRAIN: if (buf_pop && buf_last) begin
            rd_vld_q  <= 1'b0;
            addr      <= next_addr;
            remaining <= remaining - CNT_W'(1);
            if (last_burst) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              state  <= S_RD_REQ;
              rreq_q <= 1'b1;
            end
          end
          S_WR_FILL: if (buf_push && buf_last) begin
            state    <= S_WR_REQ;
            wr_rdy_q <= 1'b0;
            wreq_q   <= 1'b1;
          end
          S_WR_REQ: if (wreq_q && mem.mem_ready_i) begin
            state  <= S_WR_WAIT;
            wreq_q <= 1'b0;
          end
          S_WR_WAIT: if (mem.mem_write_done_i) begin
            addr      <= next_addr;
            remaining <= remaining - CNT_W'(1);
            if (last_burst) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              state    <= S_WR_FILL;
              wr_rdy_q <= 1'b1;
            end
          end
          S_ABORT: begin
            state   <= S_IDLE;
            inval_q <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hs_npu_mem_sequencer.sv
module tb_hs_npu_mem_sequencer;
  import hs_npu_pkg::*;
  localparam int BW = NPU_BURST_WORDS;
  localparam int CW = NPU_CNT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_write_i = 1'b0, abort_i = 1'b0;
  logic          rd_ready_i = 1'b0, wr_valid_i = 1'b0;
  logic [31:0]   cmd_base_i = '0, cmd_stride_i = '0, wr_data_i = '0;
  logic [CW-1:0] cmd_count_i = '0;
  logic          cmd_ready_o, busy_o, done_o, rd_valid_o, wr_ready_o;
  logic [31:0]   rd_data_o;

  hs_npu_mem_sequencer_if #(.BURST_WORDS(BW)) mem ();

  hs_npu_mem_sequencer #(.BURST_WORDS(BW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_base_i(cmd_base_i), .cmd_stride_i(cmd_stride_i), .cmd_count_i(cmd_count_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .mem(mem)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0;
  always @(negedge clk) if (done_o) done_cnt++;

  typedef struct {
    logic          cv, cw;
    logic [CW-1:0] cnt;
    logic          ab, mv, rr, wv;
    logic [7:0]    exp;     // {busy,cmd_ready,done,rd_req,wr_req,inval,rd_valid,wr_ready}
    logic [31:0]   exp_rd;  // checked only when rd_valid expected
  } vec_t;
  vec_t tv[16];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] stat();
    return {busy_o, cmd_ready_o, done_o, mem.mem_read_ready_o, mem.mem_write_valid_o,
            mem.mem_invalidate_o, rd_valid_o, wr_ready_o};
  endfunction

  function automatic logic [31:0] mdata(input logic [31:0] a, input int k);
    return a ^ (32'h5A00_0000 + 32'(k));
  endfunction

  task automatic run_read(input logic [31:0] base, input logic [31:0] stride,
                          input int cnt, input bit toggle);
    logic [31:0] got[$];
    logic [31:0] addrs[$];
    logic [31:0] held, ea;
    int d0, lat, post, unstable;
    bit stalled;
    d0 = done_cnt; lat = 0; post = -1; unstable = 0; stalled = 0; held = '0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_base_i = base; cmd_stride_i = stride;
    cmd_count_i = CW'(cnt);
    rd_ready_i = toggle ? 1'b0 : 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    chk("rd first req", 64'({mem.mem_read_ready_o, mem.mem_addr_o}), 64'({1'b1, base}));
    for (int cyc = 0; cyc < 400 && post != 0; cyc++) begin
      if (stalled && !(rd_valid_o && rd_data_o == held)) unstable++;
      mem.mem_valid_i = 1'b0;
      if (mem.mem_read_ready_o) begin
        lat++;
        if (lat == 3) begin
          lat = 0;
          mem.mem_valid_i = 1'b1;
          addrs.push_back(mem.mem_addr_o);
          for (int k = 0; k < BW; k++) mem.mem_rdata_i[k] = mdata(mem.mem_addr_o, k);
        end
      end
      if (toggle) rd_ready_i = ~rd_ready_i;
      if (rd_valid_o && rd_ready_i) got.push_back(rd_data_o);
      stalled = rd_valid_o && !rd_ready_i;
      held = rd_data_o;
      if (post > 0) post--;
      else if (post < 0 && done_o) post = 2;
      tick();
    end
    mem.mem_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    chk("rd done pulses", 64'(done_cnt - d0), 64'(1));
    chk("rd busy after", 64'(busy_o), 64'(0));
    chk("rd burst count", 64'(addrs.size()), 64'(cnt));
    chk("rd word count", 64'(got.size()), 64'(cnt * BW));
    chk("rd stall stability", 64'(unstable), 64'(0));
    for (int b = 0; b < cnt; b++) begin
      ea = base + stride * 32'(b);
      chk($sformatf("rd addr %0d", b), 64'((b < addrs.size()) ? addrs[b] : ~ea), 64'(ea));
      for (int k = 0; k < BW; k++)
        chk($sformatf("rd word %0d.%0d", b, k),
            64'((b * BW + k < got.size()) ? got[b * BW + k] : ~mdata(ea, k)), 64'(mdata(ea, k)));
    end
  endtask

  task automatic run_write(input logic [31:0] base, input logic [31:0] stride, input int cnt);
    logic [31:0] waddr[$];
    logic [31:0] wdat[$];
    logic [BW-1:0][31:0] held;
    logic [31:0] ea;
    int d0, nw, wait_cnt, viol, post;
    d0 = done_cnt; nw = 0; wait_cnt = -1; viol = 0; post = -1; held = '0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_base_i = base; cmd_stride_i = stride;
    cmd_count_i = CW'(cnt);
    tick();
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 400 && post != 0; cyc++) begin
      mem.mem_write_done_i = 1'b0;
      if (wait_cnt > 0) begin
        // Burst handed off: no new request, no new words, burst data held.
        if (mem.mem_write_valid_o || wr_ready_o || mem.mem_wdata_o != held) viol++;
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem.mem_write_done_i = 1'b1;
          wait_cnt = -1;
        end
      end
      mem.mem_ready_i = mem.mem_write_valid_o ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mem.mem_write_valid_o && mem.mem_ready_i) begin
        waddr.push_back(mem.mem_addr_o);
        for (int k = 0; k < BW; k++) wdat.push_back(mem.mem_wdata_o[k]);
        held = mem.mem_wdata_o;
        wait_cnt = 3;
      end
      wr_valid_i = (nw < cnt * BW) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_data_i = 32'hA0 + 32'(nw);
      if (wr_valid_i && wr_ready_o) nw++;
      if (post > 0) post--;
      else if (post < 0 && done_o) post = 2;
      tick();
    end
    mem.mem_ready_i = 1'b0; mem.mem_write_done_i = 1'b0; wr_valid_i = 1'b0;
    chk("wr done pulses", 64'(done_cnt - d0), 64'(1));
    chk("wr busy after", 64'(busy_o), 64'(0));
    chk("wr burst count", 64'(waddr.size()), 64'(cnt));
    chk("wr wait hold", 64'(viol), 64'(0));
    for (int b = 0; b < cnt; b++) begin
      ea = base + stride * 32'(b);
      chk($sformatf("wr addr %0d", b), 64'((b < waddr.size()) ? waddr[b] : ~ea), 64'(ea));
      for (int k = 0; k < BW; k++)
        chk($sformatf("wr word %0d.%0d", b, k),
            64'((b * BW + k < wdat.size()) ? wdat[b * BW + k] : 32'h0),
            64'(32'hA0 + 32'(b * BW + k)));
    end
  endtask

  initial begin
    int d0;
    mem.mem_ready_i = 1'b0; mem.mem_valid_i = 1'b0; mem.mem_write_done_i = 1'b0;
    mem.mem_rdata_i = '0;

    tv[0]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0000, 32'h0};
    tv[1]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0100_0000, 32'h0};
    tv[2]  = '{1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0110_0000, 32'h0};
    tv[3]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0100_0000, 32'h0};
    tv[4]  = '{1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1001_0000, 32'h0};
    tv[5]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1001_0000, 32'h0};
    tv[6]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1000_0010, 32'h11};
    tv[7]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_0010, 32'h11};
    tv[8]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b1000_0010, 32'h22};
    tv[9]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0110_0000, 32'h0};
    tv[10] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0100_0000, 32'h0};
    tv[11] = '{1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1000_0001, 32'h0};
    tv[12] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1000_0100, 32'h0};
    tv[13] = '{1'b1, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0100_0000, 32'h0};
    tv[14] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0100_0000, 32'h0};
    tv[15] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0100_0000, 32'h0};

    #1;
    chk("reset status", 64'(stat()), 64'(8'b0100_0000));
    chk("reset addr/rdata", 64'({mem.mem_addr_o, rd_data_o}), 64'(0));
    #11 rst_n = 1'b1;
    tick();

    // Cycle table: empty commands, a one-burst read with a stall, abort in
    // WR_FILL, command refused during abort, abort and mem_valid in idle.
    cmd_base_i = 32'h100; cmd_stride_i = 32'h10;
    mem.mem_rdata_i[0] = 32'h11; mem.mem_rdata_i[1] = 32'h22;
    wr_data_i = 32'h55;
    for (int i = 0; i < 16; i++) begin
      cmd_valid_i = tv[i].cv; cmd_write_i = tv[i].cw; cmd_count_i = tv[i].cnt;
      abort_i = tv[i].ab; mem.mem_valid_i = tv[i].mv; rd_ready_i = tv[i].rr;
      wr_valid_i = tv[i].wv;
      tick();
      chk($sformatf("vec%0d status", i), 64'(stat()), 64'(tv[i].exp));
      if (tv[i].exp[1]) chk($sformatf("vec%0d rd_data", i), 64'(rd_data_o), 64'(tv[i].exp_rd));
    end
    cmd_valid_i = 1'b0; abort_i = 1'b0; mem.mem_valid_i = 1'b0; rd_ready_i = 1'b0;
    wr_valid_i = 1'b0;
    tick();

    run_read(32'h1000, 32'h40, 3, 1'b0);
    run_read(32'h3000, 32'h20, 2, 1'b1);
    run_write(32'h2000, 32'h8, 2);

    // Abort while the second read burst is being requested.
    d0 = done_cnt;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_base_i = 32'h4000; cmd_stride_i = 32'h100;
    cmd_count_i = CW'(3);
    tick();
    cmd_valid_i = 1'b0;
    mem.mem_valid_i = 1'b1; mem.mem_rdata_i[0] = 32'h1; mem.mem_rdata_i[1] = 32'h2;
    tick();
    mem.mem_valid_i = 1'b0; rd_ready_i = 1'b1;
    tick();
    tick();
    rd_ready_i = 1'b0;
    chk("ab second req", 64'({mem.mem_read_ready_o, mem.mem_addr_o}), 64'({1'b1, 32'h4100}));
    abort_i = 1'b1; mem.mem_valid_i = 1'b1;
    tick();
    abort_i = 1'b0; mem.mem_valid_i = 1'b0;
    chk("ab abort cycle", 64'(stat()), 64'(8'b1000_0100));
    tick();
    chk("ab back idle", 64'(stat()), 64'(8'b0100_0000));
    chk("ab no done", 64'(done_cnt - d0), 64'(0));
    cmd_valid_i = 1'b1; cmd_base_i = 32'h5000; cmd_count_i = CW'(1);
    tick();
    cmd_valid_i = 1'b0;
    chk("ab new cmd", 64'({busy_o, mem.mem_read_ready_o, mem.mem_addr_o}), 64'({2'b11, 32'h5000}));
    mem.mem_valid_i = 1'b1; mem.mem_rdata_i[0] = 32'h77; mem.mem_rdata_i[1] = 32'h88;
    tick();
    mem.mem_valid_i = 1'b0; rd_ready_i = 1'b1;
    chk("ab new rd word0", 64'({rd_valid_o, rd_data_o}), 64'({1'b1, 32'h77}));
    tick();
    chk("ab new rd word1", 64'({rd_valid_o, rd_data_o}), 64'({1'b1, 32'h88}));
    tick();
    rd_ready_i = 1'b0;
    chk("ab new done", 64'(stat()), 64'(8'b0110_0000));
    tick();

    // Reset asserted while a write burst waits for completion.
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_base_i = 32'h6000; cmd_stride_i = 32'h4;
    cmd_count_i = CW'(1);
    tick();
    cmd_valid_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 32'hB0;
    tick();
    wr_data_i = 32'hB1;
    tick();
    wr_valid_i = 1'b0; mem.mem_ready_i = 1'b1;
    tick();
    mem.mem_ready_i = 1'b0;
    chk("rst in wr_wait", 64'(stat()), 64'(8'b1000_0000));
    #2 rst_n = 1'b0;
    #1;
    chk("rst async status", 64'(stat()), 64'(8'b0100_0000));
    chk("rst async addr/rdata", 64'({mem.mem_addr_o, rd_data_o}), 64'(0));
    chk("rst async wdata", 64'(mem.mem_wdata_o), 64'(0));
    rst_n = 1'b1;
    tick();
    run_read(32'h7000, 32'h4, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hs_npu_mem_sequencer.md
Name: hs_npu_mem_sequencer

Overview:
- Upstream ordering/sequencing stage for the NPU memory interface.
- Accepts a strided matrix-transfer command and splits it into per-burst read or write requests for the memory interface.
- Read path: unpacks each returned burst into a word stream for the operand buffers.
- Write path: packs a result word stream into bursts.

Parameters:
- BURST_WORDS, 2, 32-bit words per burst; must match the memory interface burst.
- CNT_W, 16, width of the burst-count field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  sequencer can accept a command
- cmd_write_i  in  1  1 = write transfer, 0 = read transfer
- cmd_base_i  in  32  byte address of the first burst
- cmd_stride_i  in  32  byte offset between consecutive bursts
- cmd_count_i  in  CNT_W  number of bursts
- abort_i  in  1  cancel the current command
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- rd_data_o  out  32  read word stream data
- rd_valid_o  out  1  read word valid
- rd_ready_i  in  1  read word accepted
- wr_data_i  in  32  write word stream data
- wr_valid_i  in  1  write word valid
- wr_ready_o  out  1  write word accepted
- mem_read_ready_o  out  1  read request / read-data ready to memory interface
- mem_write_valid_o  out  1  write request to memory interface
- mem_invalidate_o  out  1  invalidate an outstanding read
- mem_ready_i  in  1  memory interface available
- mem_valid_i  in  1  read burst data valid (1-cycle pulse)
- mem_write_done_i  in  1  write burst completed (1-cycle pulse)
- mem_addr_o  out  32  request address
- mem_rdata_i  in  32 x BURST_WORDS  read burst data
- mem_wdata_o  out  32 x BURST_WORDS  write burst data

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; all outputs 0, except cmd_ready_o = 1.
  - Buffers, counters and address register cleared.
- States: IDLE, RD_REQ, RD_DRAIN, WR_FILL, WR_REQ, WR_WAIT, ABORT.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch base, stride, count, write; set addr = base, remaining = count, go to RD_REQ or WR_FILL.
  - If count = 0, go directly to IDLE and pulse done_o on the next cycle.
- RD_REQ:
  - Hold mem_read_ready_o = 1 and mem_addr_o = addr until mem_valid_i.
  - On mem_valid_i, capture all mem_rdata_i words into the burst buffer in the same cycle, then go to RD_DRAIN.
  - mem_read_ready_o drops in the cycle after the capture.
- RD_DRAIN:
  - rd_valid_o = 1; rd_data_o = buffer[idx], idx from 0 to BURST_WORDS-1.
  - Advance idx on rd_valid_o & rd_ready_i; rd_data_o stays stable while stalled.
  - After the last word: addr += stride (modulo 2^32), remaining -= 1.
  - If remaining = 0, go to IDLE with done_o pulsed; otherwise go to RD_REQ.
- WR_FILL:
  - wr_ready_o = 1; each accepted word goes to buffer[idx].
  - After BURST_WORDS words, go to WR_REQ.
- WR_REQ:
  - mem_wdata_o = buffer, held stable through WR_WAIT; mem_addr_o = addr.
  - mem_write_valid_o = 1 while mem_ready_i is low.
  - The first cycle mem_ready_i is high with mem_write_valid_o set counts as accepted; go to WR_WAIT.
- WR_WAIT:
  - mem_write_valid_o = 0; wait for mem_write_done_i.
  - Then update addr and remaining as on the read side; go to WR_FILL, or to IDLE with done_o pulsed.
- Latency:
  - Command accept to first memory request: 1 cycle on read.
  - mem_valid_i to first rd_valid_o: 1 cycle.
- abort_i (priority over all events in the same cycle):
  - Go to ABORT for 1 cycle with mem_invalidate_o = 1 and all request and stream valids low, then IDLE.
  - No done_o pulse.
  - An abort in IDLE is ignored.
- Status outputs:
  - busy_o = (state != IDLE).
  - cmd_ready_o = 0 whenever not in IDLE.
- Write-side limits:
  - A command during an abort or while busy is not accepted.
  - mem_valid_i outside RD_REQ is ignored.
- Stream stalls:
  - rd_ready_i low indefinitely stalls with no data loss.
  - wr_valid_i gaps stall WR_FILL.
- remaining is CNT_W wide; count = 2^CNT_W - 1 must complete exactly that many bursts.

Decomposition:
- hs_npu_pkg gains:
  - typedef seq_state_t (the seven states);
  - typedef mem_cmd_t (write, base, stride, count);
  - constant NPU_BURST_WORDS = 2, shared with the memory interface.
- Sub-module hs_npu_burst_buffer: BURST_WORDS x 32 register file with word index counter, parallel load/unload and serial push/pop. Instantiated once and shared by the read and write paths, since the two never run at the same time.

Test Plan:
- Read, count = 3, base = 0x1000, stride = 0x40, rd_ready_i = 1:
  - mem_addr_o sequence 0x1000, 0x1040, 0x1080;
  - 6 rd words equal to the model data, in order;
  - done_o pulses once; busy_o = 0 afterwards.
- Read with rd_ready_i toggling 1/0 every cycle: rd_data_o stable while stalled; no word dropped or duplicated.
- Write, count = 2, base = 0x2000, stride = 8, words 0xA0..0xA3 with random wr_valid_i gaps:
  - mem_wdata_o = {0xA0, 0xA1} at 0x2000, then {0xA2, 0xA3} at 0x2008;
  - each burst waits for mem_write_done_i.
- Count = 0 command: no mem_read_ready_o or mem_write_valid_o activity; done_o pulses 1 cycle after acceptance.
- Abort during RD_REQ on the second burst: mem_invalidate_o high 1 cycle; returns to IDLE; no done_o; a new command is accepted the next cycle.
- Assert rst_n low mid-WR_WAIT: all outputs 0 and cmd_ready_o = 1 immediately; a subsequent read command runs cleanly.
